// File: rtl/status_sync_wb_if.sv
// Bus bundle for status_sync_wb: event/level inputs, pending/interrupt outputs
// and the per-channel counter readback.
interface status_sync_wb_if #(
   parameter int NUM_TOG   = 8,
   parameter int NUM_LVL   = 2,
   parameter int CNT_WIDTH = 16
);
   localparam int SEL_W    = (NUM_TOG > 1) ? $clog2(NUM_TOG) : 1;
   localparam int NUM_PEND = NUM_TOG + NUM_LVL;

   logic [NUM_TOG-1:0]   tog_i;
   logic [NUM_LVL-1:0]   lvl_i;
   logic [NUM_TOG-1:0]   pulse_o;
   logic [NUM_LVL-1:0]   lvl_o;
   logic [NUM_PEND-1:0]  pend_o;
   logic [NUM_PEND-1:0]  int_mask_i;
   logic [NUM_PEND-1:0]  pend_clr_i;
   logic                 int_o;
   logic [SEL_W-1:0]     cnt_sel_i;
   logic                 cnt_clr_i;
   logic [CNT_WIDTH-1:0] cnt_o;

   modport master (
      output tog_i, lvl_i, int_mask_i, pend_clr_i, cnt_sel_i, cnt_clr_i,
      input  pulse_o, lvl_o, pend_o, int_o, cnt_o
   );

   modport slave (
      input  tog_i, lvl_i, int_mask_i, pend_clr_i, cnt_sel_i, cnt_clr_i,
      output pulse_o, lvl_o, pend_o, int_o, cnt_o
   );
endinterface

// File: rtl/status_sync_wb.sv
// Synchronizes toggle events and filtered levels into sticky pending bits and an interrupt.
// Optional per-channel event counters are built when STATUS_SYNC_CNT_EN is defined.
module status_sync_wb #(
   parameter int NUM_TOG     = 8,
   parameter int NUM_LVL     = 2,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYC    = 4,
   parameter int CNT_WIDTH   = 16
) (
   input logic             wb_clk_i,
   input logic             wb_rst_i,
   status_sync_wb_if.slave bus
);
   localparam int NUM_PEND = NUM_TOG + NUM_LVL;
   localparam int SUP_LEN  = SYNC_STAGES + 1;
   localparam int SEL_W    = (NUM_TOG > 1) ? $clog2(NUM_TOG) : 1;

   logic [SYNC_STAGES-1:0][NUM_TOG-1:0] tog_sync_q;
   logic [SYNC_STAGES-1:0][NUM_LVL-1:0] lvl_sync_q;
   logic [NUM_TOG-1:0]  tog_sync, tog_hist_q, pulse_q, pulse_d;
   logic [NUM_LVL-1:0]  lvl_sync, lvl_q, lvl_prev_q;
   logic [NUM_PEND-1:0] pend_q, pend_d;
   logic                int_q;
   logic [2:0]          sup_q;
   logic                sup_active;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         tog_sync_q <= '0;
         lvl_sync_q <= '0;
      end else begin
         tog_sync_q <= {tog_sync_q[SYNC_STAGES-2:0], bus.tog_i};
         lvl_sync_q <= {lvl_sync_q[SYNC_STAGES-2:0], bus.lvl_i};
      end
   end

   assign tog_sync = tog_sync_q[SYNC_STAGES-1];
   assign lvl_sync = lvl_sync_q[SYNC_STAGES-1];

   // Events are masked until the synchronizers and edge history hold real input samples.
   assign sup_active = (sup_q < 3'(SUP_LEN));
   assign pulse_d    = (tog_sync ^ tog_hist_q) & {NUM_TOG{~sup_active}};
   assign pend_d     = (pend_q & ~bus.pend_clr_i) | {lvl_q & ~lvl_prev_q, pulse_q};

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sup_q      <= '0;
         tog_hist_q <= '0;
         pulse_q    <= '0;
         lvl_prev_q <= '0;
         pend_q     <= '0;
         int_q      <= 1'b0;
      end else begin
         if (sup_active) sup_q <= sup_q + 3'd1;
         tog_hist_q <= tog_sync;
         pulse_q    <= pulse_d;
         lvl_prev_q <= lvl_q;
         pend_q     <= pend_d;
         int_q      <= |(pend_q & bus.int_mask_i);
      end
   end

   if (FILT_CYC == 0) begin : g_nofilt
      always_ff @(posedge wb_clk_i) begin
         if (wb_rst_i) lvl_q <= '0;
         else          lvl_q <= lvl_sync;
      end
   end else begin : g_filt
      localparam int FW = $clog2(FILT_CYC + 1);
      logic [NUM_LVL-1:0][FW-1:0] filt_cnt_q, filt_cnt_d;
      logic [NUM_LVL-1:0]         lvl_d;

      // NOTE: every always_comb output gets a default first so no latch is inferred.
      always_comb begin
         filt_cnt_d = filt_cnt_q;
         lvl_d      = lvl_q;
         for (int j = 0; j < NUM_LVL; j++) begin
            if (lvl_sync[j] == lvl_q[j]) begin
               filt_cnt_d[j] = '0;
            end else if (filt_cnt_q[j] == FW'(FILT_CYC - 1)) begin
               lvl_d[j]      = lvl_sync[j];
               filt_cnt_d[j] = '0;
            end else begin
               filt_cnt_d[j] = filt_cnt_q[j] + 1'b1;
            end
         end
      end

      always_ff @(posedge wb_clk_i) begin
         if (wb_rst_i) begin
            filt_cnt_q <= '0;
            lvl_q      <= '0;
         end else begin
            filt_cnt_q <= filt_cnt_d;
            lvl_q      <= lvl_d;
         end
      end
   end

`ifdef STATUS_SYNC_CNT_EN
   logic [NUM_TOG-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]              cnt_o_q, cnt_o_d;

   // A clear that coincides with an event leaves that event counted.
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < NUM_TOG; i++) begin
         if (bus.cnt_clr_i && (bus.cnt_sel_i == SEL_W'(i)))
            cnt_d[i] = CNT_WIDTH'(pulse_q[i]);
         else if (pulse_q[i] && (cnt_q[i] != '1))
            cnt_d[i] = cnt_q[i] + 1'b1;
      end
      cnt_o_d = (int'(bus.cnt_sel_i) < NUM_TOG) ? cnt_q[bus.cnt_sel_i] : '0;
   end

   // NOTE: the counter array is reset explicitly since software reads it right after reset.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cnt_q   <= '0;
         cnt_o_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         cnt_o_q <= cnt_o_d;
      end
   end

   assign bus.cnt_o = cnt_o_q;
`else
   logic unused_cnt_in;
   assign unused_cnt_in = ^{bus.cnt_sel_i, bus.cnt_clr_i};
   assign bus.cnt_o     = {CNT_WIDTH{1'b0}};
`endif

   assign bus.pulse_o = pulse_q;
   assign bus.lvl_o   = lvl_q;
   assign bus.pend_o  = pend_q;
   assign bus.int_o   = int_q;
endmodule

// File: tb/tb_status_sync_wb.sv
// Self-checking bench for status_sync_wb: sample-history reference model checked every
// cycle plus directed scenarios with hand-derived expectations.
module tb_status_sync_wb;
   localparam int NT = 8;
   localparam int NL = 2;
   localparam int SS = 2;
   localparam int FC = 4;
   localparam int CW = 4;
   localparam int NP = NT + NL;
`ifdef STATUS_SYNC_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   status_sync_wb_if #(.NUM_TOG(NT), .NUM_LVL(NL), .CNT_WIDTH(CW)) bus ();

   status_sync_wb #(
      .NUM_TOG(NT), .NUM_LVL(NL), .SYNC_STAGES(SS), .FILT_CYC(FC), .CNT_WIDTH(CW)
   ) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: keeps the raw input samples taken at each edge and derives the
   // outputs from "an event is a change between consecutive samples, seen SS edges late".
   logic [NT-1:0] tq[$];
   logic [NL-1:0] lq[$];
   int            since;
   int            run_len[NL];
   logic [NT-1:0] m_pulse, n_pulse;
   logic [NL-1:0] m_lvl, m_lvl_prev, n_lvl;
   logic [NP-1:0] m_pend, n_pend;
   logic          m_int, n_int;
   logic [CW-1:0] m_cnt[NT];
   logic [CW-1:0] m_cnt_o, n_cnt_o;
   bit            m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         tq = {};
         lq = {};
         for (int k = 0; k < SS + 2; k++) begin
            tq.push_front('0);
            lq.push_front('0);
         end
         since = 0;
         m_pulse = '0; m_lvl = '0; m_lvl_prev = '0;
         m_pend = '0; m_int = 1'b0; m_cnt_o = '0;
         for (int j = 0; j < NL; j++) run_len[j] = 0;
         for (int i = 0; i < NT; i++) m_cnt[i] = '0;
         m_valid = 1'b1;
      end else begin
         n_int   = |(m_pend & bus.int_mask_i);
         n_pend  = (m_pend & ~bus.pend_clr_i) | {m_lvl & ~m_lvl_prev, m_pulse};
         n_cnt_o = CNT_EN ? m_cnt[bus.cnt_sel_i] : '0;
         if (CNT_EN) begin
            for (int i = 0; i < NT; i++) begin
               if (bus.cnt_clr_i && (int'(bus.cnt_sel_i) == i))
                  m_cnt[i] = m_pulse[i] ? CW'(1) : CW'(0);
               else if (m_pulse[i] && m_cnt[i] != {CW{1'b1}})
                  m_cnt[i] = m_cnt[i] + CW'(1);
            end
         end
         tq.push_front(bus.tog_i); void'(tq.pop_back());
         lq.push_front(bus.lvl_i); void'(lq.pop_back());
         if (since < 1000) since++;
         n_pulse = (since > SS + 1) ? (tq[SS] ^ tq[SS+1]) : '0;
         n_lvl = m_lvl;
         for (int j = 0; j < NL; j++) begin
            if (lq[SS][j] == m_lvl[j]) run_len[j] = 0;
            else begin
               run_len[j]++;
               if (run_len[j] >= FC) begin
                  n_lvl[j]   = lq[SS][j];
                  run_len[j] = 0;
               end
            end
         end
         m_lvl_prev = m_lvl;
         m_lvl      = n_lvl;
         m_pulse    = n_pulse;
         m_pend     = n_pend;
         m_int      = n_int;
         m_cnt_o    = n_cnt_o;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_pulse", 32'(bus.pulse_o), 32'(m_pulse));
         check("model_lvl",   32'(bus.lvl_o),   32'(m_lvl));
         check("model_pend",  32'(bus.pend_o),  32'(m_pend));
         check("model_int",   32'(bus.int_o),   32'(m_int));
         check("model_cnt",   32'(bus.cnt_o),   32'(m_cnt_o));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
      $fatal(1);
   end

   localparam logic [NT-1:0] TOG_PAT[5] = '{8'h01, 8'h81, 8'h3C, 8'hFF, 8'h42};
   localparam logic [NP-1:0] CLR_PAT[5] = '{10'h000, 10'h081, 10'h3FF, 10'h000, 10'h200};

   initial begin
      bus.tog_i      = '1;
      bus.lvl_i      = '0;
      bus.int_mask_i = '0;
      bus.pend_clr_i = '0;
      bus.cnt_sel_i  = '0;
      bus.cnt_clr_i  = 1'b0;
      rst            = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_pulse", 32'(bus.pulse_o), 32'h0);
      check("rst_lvl",   32'(bus.lvl_o),   32'h0);
      check("rst_pend",  32'(bus.pend_o),  32'h0);
      check("rst_int",   32'(bus.int_o),   32'h0);
      check("rst_cnt",   32'(bus.cnt_o),   32'h0);

      // Inputs static-high across reset release must not produce events.
      rst = 1'b0;
      repeat (12) begin
         @(negedge clk);
         check("static_hi_pulse", 32'(bus.pulse_o), 32'h0);
      end
      check("static_hi_pend", 32'(bus.pend_o), 32'h0);

      // Single toggle on channel 3, interrupt enabled.
      bus.int_mask_i = 10'h008;
      bus.tog_i[3]   = ~bus.tog_i[3];
      repeat (2) @(negedge clk);
      check("t3_early", 32'(bus.pulse_o), 32'h0);
      @(negedge clk);
      check("t3_pulse", 32'(bus.pulse_o), 32'h08);
      @(negedge clk);
      check("t3_width", 32'(bus.pulse_o), 32'h0);
      check("t3_pend",  32'(bus.pend_o),  32'h008);
      check("t3_int_lag", 32'(bus.int_o), 32'h0);
      @(negedge clk);
      check("t3_int", 32'(bus.int_o), 32'h1);

      bus.pend_clr_i = 10'h008;
      @(negedge clk);
      bus.pend_clr_i = '0;
      check("clr_pend", 32'(bus.pend_o), 32'h0);

      // Same event with the interrupt masked.
      bus.int_mask_i = '0;
      bus.tog_i[3]   = ~bus.tog_i[3];
      repeat (5) @(negedge clk);
      check("nomask_pend", 32'(bus.pend_o), 32'h008);
      check("nomask_int",  32'(bus.int_o),  32'h0);

      // Clear coinciding with a new set: set wins, the next clear takes effect.
      bus.pend_clr_i = 10'h008;
      @(negedge clk);
      bus.pend_clr_i = '0;
      check("preclr_pend", 32'(bus.pend_o[3]), 32'h0);
      bus.tog_i[3] = ~bus.tog_i[3];
      repeat (3) @(negedge clk);
      check("sw_pulse", 32'(bus.pulse_o), 32'h08);
      bus.pend_clr_i = 10'h008;
      @(negedge clk);
      check("set_wins", 32'(bus.pend_o[3]), 32'h1);
      @(negedge clk);
      bus.pend_clr_i = '0;
      check("clr_after", 32'(bus.pend_o[3]), 32'h0);

      // Level glitch shorter than the filter, then a long level.
      bus.lvl_i[1] = 1'b1;
      repeat (3) @(negedge clk);
      bus.lvl_i[1] = 1'b0;
      repeat (12) begin
         @(negedge clk);
         check("glitch_lvl", 32'(bus.lvl_o[1]), 32'h0);
      end
      bus.lvl_i[1] = 1'b1;
      repeat (10) @(negedge clk);
      check("lvl_rise", 32'(bus.lvl_o), 32'h2);
      check("lvl_pend", 32'(bus.pend_o[9]), 32'h1);

      // Mixed toggle/clear patterns, checked by the model.
      bus.int_mask_i = '1;
      bus.cnt_sel_i  = 3'd3;
      for (int k = 0; k < 5; k++) begin
         bus.tog_i      = bus.tog_i ^ TOG_PAT[k];
         bus.pend_clr_i = CLR_PAT[k];
         @(negedge clk);
         bus.pend_clr_i = '0;
         repeat (3) @(negedge clk);
      end
      bus.pend_clr_i = '1;
      repeat (6) @(negedge clk);
      bus.pend_clr_i = '0;

      // Counter saturation and clear-with-increment on channel 0.
      bus.cnt_sel_i = '0;
      for (int k = 0; k < 20; k++) begin
         bus.tog_i[0] = ~bus.tog_i[0];
         repeat (2) @(negedge clk);
      end
      repeat (6) @(negedge clk);
`ifdef STATUS_SYNC_CNT_EN
      check("cnt_sat", 32'(bus.cnt_o), 32'hF);
`else
      check("cnt_off", 32'(bus.cnt_o), 32'h0);
`endif
      bus.tog_i[0] = ~bus.tog_i[0];
      repeat (3) @(negedge clk);
      check("cc_pulse", 32'(bus.pulse_o[0]), 32'h1);
      bus.cnt_clr_i = 1'b1;
      @(negedge clk);
      bus.cnt_clr_i = 1'b0;
      @(negedge clk);
`ifdef STATUS_SYNC_CNT_EN
      check("cnt_clr_inc", 32'(bus.cnt_o), 32'h1);
`else
      check("cnt_clr_off", 32'(bus.cnt_o), 32'h0);
`endif

      // One-cycle reset with an event in flight.
      bus.tog_i[5] = ~bus.tog_i[5];
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_pulse", 32'(bus.pulse_o), 32'h0);
      check("mid_rst_lvl",   32'(bus.lvl_o),   32'h0);
      check("mid_rst_pend",  32'(bus.pend_o),  32'h0);
      check("mid_rst_int",   32'(bus.int_o),   32'h0);
      check("mid_rst_cnt",   32'(bus.cnt_o),   32'h0);
      repeat (8) begin
         @(negedge clk);
         check("post_rst_pulse", 32'(bus.pulse_o), 32'h0);
      end
      bus.tog_i[2] = ~bus.tog_i[2];
      repeat (3) @(negedge clk);
      check("post_rst_event", 32'(bus.pulse_o), 32'h04);
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/status_sync_wb.md
STATUS_SYNC_WB -- requirements
Module: status_sync_wb

Interface
Parameters (name, default, meaning):
REQ-001 NUM_TOG, 8, number of toggle-encoded event channels.
REQ-002 NUM_LVL, 2, number of level status channels.
REQ-003 SYNC_STAGES, 2, synchronizer flop depth; legal values 2..4.
REQ-004 FILT_CYC, 4, level glitch-filter length in cycles; 0 bypasses the filter.
REQ-005 CNT_WIDTH, 16, width of each per-channel event counter.

Ports (name, direction, width, meaning):
REQ-006 wb_clk_i  in  1  the only clock; all logic is on its rising edge.
REQ-007 wb_rst_i  in  1  reset, synchronous and active-high.
REQ-008 tog_i  in  NUM_TOG  asynchronous toggle inputs; each transition is one event.
REQ-009 lvl_i  in  NUM_LVL  asynchronous level status inputs.
REQ-010 pulse_o  out  NUM_TOG  one-cycle event pulse per channel.
REQ-011 lvl_o  out  NUM_LVL  synchronized and filtered levels.
REQ-012 pend_o  out  NUM_TOG+NUM_LVL  sticky pending bits; toggles in the low bits, level rising edges in the high bits.
REQ-013 int_mask_i  in  NUM_TOG+NUM_LVL  1 enables the corresponding pending bit onto int_o.
REQ-014 pend_clr_i  in  NUM_TOG+NUM_LVL  write-one-to-clear strobe, sampled every cycle.
REQ-015 int_o  out  1  registered interrupt request.
REQ-016 cnt_sel_i  in  clog2(NUM_TOG)  counter select.
REQ-017 cnt_clr_i  in  1  clears the selected counter.
REQ-018 cnt_o  out  CNT_WIDTH  registered value of the selected counter.

Function
REQ-019 Each tog_i and lvl_i bit SHALL pass through SYNC_STAGES flops before any use.
REQ-020 pulse_o[i] SHALL be registered and high for exactly one cycle when synchronized tog_i[i] differs from its previous synchronized value.
REQ-021 Latency from the first rising edge that samples a tog_i change to pulse_o SHALL be SYNC_STAGES+1 cycles.
REQ-022 Rise and fall of tog_i SHALL each produce one pulse.
REQ-023 Level filter: lvl_o[j] SHALL take the synchronized value only after it differs from lvl_o[j] for FILT_CYC consecutive cycles.
REQ-024 Level filter: any agreement between the synchronized value and lvl_o[j] SHALL restart that filter counter.
REQ-025 With FILT_CYC=0, lvl_o SHALL be the last synchronizer stage registered once.
REQ-026 pend_o[i] SHALL set on pulse_o[i].
REQ-027 pend_o[NUM_TOG+j] SHALL set on a 0->1 transition of lvl_o[j].
REQ-028 A pending bit SHALL clear the cycle after pend_clr_i is high for that bit.
REQ-029 If set and clear coincide on the same bit, set SHALL win.
REQ-030 int_o SHALL equal the registered OR of (pend_o AND int_mask_i), one cycle after pend_o.
REQ-031 Startup suppression: after reset release, pulse_o and pending set SHALL be inhibited for SYNC_STAGES+1 cycles while the edge-detect history loads, so inputs static-high at reset create no events.
REQ-032 Startup suppression: the suppression counter SHALL saturate and stay inactive until the next reset.

Reset
REQ-033 While wb_rst_i is high on a clock edge, the following SHALL be 0 on that edge: all synchronizer flops, edge history, filter counters, counters, pulse_o, lvl_o, pend_o, int_o and cnt_o.
REQ-034 wb_rst_i asserted mid-event SHALL discard in-flight events; no pulse SHALL be emitted for them.

Configuration
REQ-035 With macro STATUS_SYNC_CNT_EN defined, each toggle channel SHALL have a saturating CNT_WIDTH counter incremented on pulse_o[i].
REQ-036 With STATUS_SYNC_CNT_EN defined, cnt_o SHALL show counter[cnt_sel_i] one cycle after the select.
REQ-037 With STATUS_SYNC_CNT_EN defined, cnt_clr_i SHALL zero the selected counter; clear with a coincident increment SHALL yield 1.
REQ-038 With STATUS_SYNC_CNT_EN undefined, no counter logic SHALL exist, cnt_o SHALL be constant 0, and cnt_sel_i and cnt_clr_i SHALL be ignored.

Verification
REQ-039 Defaults; toggle tog_i[3] once after the startup window -> pulse_o[3] high exactly 1 cycle, 3 cycles later; pend_o[3]=1; int_o=1 next cycle if int_mask_i[3]=1, else stays 0.
REQ-040 Hold tog_i=8'hFF through reset release -> no pulse_o and pend_o=0 for the whole run.
REQ-041 FILT_CYC=4; lvl_i[1] high for 3 cycles then low -> lvl_o[1] stays 0; high for 10 cycles -> lvl_o[1]=1 and pend_o[9]=1.
REQ-042 pend_clr_i[3] driven in the same cycle as a new pulse_o[3] -> pend_o[3] stays 1; clear one cycle later -> 0.
REQ-043 STATUS_SYNC_CNT_EN defined, CNT_WIDTH=4; 20 toggles on channel 0 -> cnt_o=4'hF; cnt_clr_i with a coincident pulse -> cnt_o=1.
REQ-044 Pulse wb_rst_i high one cycle mid-operation -> all outputs 0 the next cycle, then the suppression window restarts.
